// File: rtl/rf_ctrl_pkg.sv
// Shared widths and the buffered writeback entry type for the register file write-port control.
package rf_ctrl_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned XLEN   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO holding multi-cycle results until the register file write port is free.
module wb_fifo
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t wdata,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register file write-port arbiter: in-order writeback wins, buffered multi-cycle results drain
// when the port is idle, and a scoreboard of in-flight long-latency destinations drives stall.
module rf_wb_arbiter #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_wd,
  input  logic            mu_valid,
  output logic            mu_ready,
  input  logic [4:0]      mu_rd,
  input  logic [XLEN-1:0] mu_wd,
  input  logic            id_we,
  input  logic            id_long,
  input  logic [4:0]      id_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            stall,
  output logic            rf_we,
  output logic [4:0]      rf_a3,
  output logic [XLEN-1:0] rf_wd,
  output logic            busy
);

  import rf_ctrl_pkg::*;

  logic [31:0] pend_q, pend_d;
  wb_entry_t   head, mu_entry;
  logic        full, empty;
  logic        wb_eff, deq, enq, hazard, sb_set;

  // Everything is gated by rst so queued entries are dropped without a write.
  assign wb_eff   = !rst && wb_we && (wb_rd != '0);
  assign deq      = !rst && !wb_eff && !empty;
  assign mu_ready = !rst && !full;
  assign enq      = mu_valid && mu_ready;
  assign mu_entry = '{rd: mu_rd, wd: mu_wd};

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (wb_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (enq),
    .wdata (mu_entry),
    .pop   (deq),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    rf_we = 1'b0;
    rf_a3 = '0;
    rf_wd = '0;
    if (wb_eff) begin
      rf_we = 1'b1;
      rf_a3 = wb_rd;
      rf_wd = wb_wd;
    end else if (deq) begin
      rf_we = (head.rd != '0);
      rf_a3 = head.rd;
      rf_wd = head.wd;
    end
  end

  assign hazard = ((rs1 != '0) && pend_q[rs1]) ||
                  ((rs2 != '0) && pend_q[rs2]) ||
                  (id_we && (id_rd != '0) && pend_q[id_rd]);
  assign stall  = !rst && hazard;
  assign sb_set = id_we && id_long && (id_rd != '0) && !stall;
  assign busy   = !rst && (!empty || (pend_q != '0));

  // A set needs the bit clear and a clear needs it set, so they never collide.
  always_comb begin
    pend_d = pend_q;
    if (deq)    pend_d[head.rd] = 1'b0;
    if (sb_set) pend_d[id_rd]   = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed cycle table for the test plan, then random traffic against a queue-based model.
module tb_rf_wb_arbiter;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst, wb_we, mu_valid, mu_ready, id_we, id_long, stall, rf_we, busy;
  logic [4:0]      wb_rd, mu_rd, id_rd, rs1, rs2, rf_a3;
  logic [XLEN-1:0] wb_wd, mu_wd, rf_wd;

  rf_wb_arbiter #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_wd    (wb_wd),
    .mu_valid (mu_valid),
    .mu_ready (mu_ready),
    .mu_rd    (mu_rd),
    .mu_wd    (mu_wd),
    .id_we    (id_we),
    .id_long  (id_long),
    .id_rd    (id_rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .stall    (stall),
    .rf_we    (rf_we),
    .rf_a3    (rf_a3),
    .rf_wd    (rf_wd),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
    logic        mu_valid;
    logic [4:0]  mu_rd;
    logic [31:0] mu_wd;
    logic        id_we, id_long;
    logic [4:0]  id_rd, rs1, rs2;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_ready, e_stall, e_busy;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  int checks = 0;
  int errors = 0;

  // Reference model: ordered list of accepted results plus a set of pending destinations.
  ent_t        q[$];
  bit          pend[32];
  logic        m_we, m_ready, m_stall, m_busy;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;

  function automatic vec_t mk(input logic r, input logic wwe, input logic [4:0] wrd,
                              input logic [31:0] wwd, input logic mv, input logic [4:0] mrd,
                              input logic [31:0] mwd, input logic iwe, input logic il,
                              input logic [4:0] ird, input logic [4:0] s1, input logic [4:0] s2,
                              input logic ewe, input logic [4:0] ea3, input logic [31:0] ewd,
                              input logic erdy, input logic est, input logic ebsy);
    vec_t v;
    v.rst = r; v.wb_we = wwe; v.wb_rd = wrd; v.wb_wd = wwd;
    v.mu_valid = mv; v.mu_rd = mrd; v.mu_wd = mwd;
    v.id_we = iwe; v.id_long = il; v.id_rd = ird; v.rs1 = s1; v.rs2 = s2;
    v.e_we = ewe; v.e_a3 = ea3; v.e_wd = ewd; v.e_ready = erdy; v.e_stall = est; v.e_busy = ebsy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_eval();
    bit any = 0;
    m_we = 0; m_a3 = '0; m_wd = '0; m_ready = 0; m_stall = 0; m_busy = 0;
    if (!rst) begin
      if (wb_we && wb_rd != 0) begin
        m_we = 1; m_a3 = wb_rd; m_wd = wb_wd;
      end else if (q.size() > 0) begin
        m_we = (q[0].rd != 0); m_a3 = q[0].rd; m_wd = q[0].wd;
      end
      for (int i = 0; i < 32; i++) any |= pend[i];
      m_ready = (q.size() < DEPTH);
      m_busy  = (q.size() > 0) || any;
      m_stall = (rs1 != 0 && pend[rs1]) || (rs2 != 0 && pend[rs2]) ||
                (id_we && id_rd != 0 && pend[id_rd]);
    end
  endtask

  task automatic model_update();
    int sz;
    if (rst) begin
      q.delete();
      for (int i = 0; i < 32; i++) pend[i] = 0;
    end else begin
      sz = q.size();
      if (!(wb_we && wb_rd != 0) && sz > 0) begin
        pend[q[0].rd] = 0;
        void'(q.pop_front());
      end
      if (mu_valid && sz < DEPTH) q.push_back('{rd: mu_rd, wd: mu_wd});
      if (id_we && id_long && id_rd != 0 && !m_stall) pend[id_rd] = 1;
      pend[0] = 0;
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; wb_we = v.wb_we; wb_rd = v.wb_rd; wb_wd = v.wb_wd;
    mu_valid = v.mu_valid; mu_rd = v.mu_rd; mu_wd = v.mu_wd;
    id_we = v.id_we; id_long = v.id_long; id_rd = v.id_rd; rs1 = v.rs1; rs2 = v.rs2;
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    // rst wwe wrd wwd mv mrd mwd iwe il ird rs1 rs2 | we a3 wd rdy stall busy
    // Reset held two cycles with mu_valid asserted
    tbl.push_back(mk(1, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0));
    // Long-latency RAW on x5
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0,   0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0,   0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 5, 'hDEADBEEF, 0, 0, 0, 5, 0,   0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0,   1, 5, 'hDEADBEEF, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0,   0, 0, 0, 1, 0, 0));
    // Contention: wb on x3 for four cycles while x7, x8 queue up
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0,   0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0,   0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 3, 'h11, 1, 7, 'h77, 0, 0, 0, 0, 0,   1, 3, 'h11, 1, 0, 1));
    tbl.push_back(mk(0, 1, 3, 'h11, 1, 8, 'h88, 0, 0, 0, 0, 0,   1, 3, 'h11, 1, 0, 1));
    tbl.push_back(mk(0, 1, 3, 'h11, 0, 0, 0, 0, 0, 0, 0, 0,   1, 3, 'h11, 0, 0, 1));
    tbl.push_back(mk(0, 1, 3, 'h11, 0, 0, 0, 0, 0, 0, 0, 0,   1, 3, 'h11, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 8,   1, 7, 'h77, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 8,   1, 8, 'h88, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 8,   0, 0, 0, 1, 0, 0));
    // x0 handling: mu_rd=0 drains silently, long id_rd=0 sets nothing, wb_rd=0 doesn't block
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 'h55, 1, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 'h55, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 10, 0, 0,   0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 10, 'hA0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 'h99, 0, 0, 0, 0, 0, 0, 0, 0,   1, 10, 'hA0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0));
    // WAW on x9
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0, 0,   0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 9, 0, 0,   0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 9, 'h9, 1, 0, 9, 0, 0,   0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 9, 0, 0,   1, 9, 'h9, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 9, 0, 0,   0, 0, 0, 1, 0, 0));
    // Reset with two entries queued under wb pressure
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 12, 0, 0,   0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3, 'h11, 1, 12, 'hC, 0, 0, 0, 0, 0,   1, 3, 'h11, 1, 0, 1));
    tbl.push_back(mk(0, 1, 3, 'h11, 1, 12, 'hD, 0, 0, 0, 0, 0,   1, 3, 'h11, 1, 0, 1));
    tbl.push_back(mk(1, 1, 3, 'h11, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0,   0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0));

    foreach (tbl[i]) begin
      v = tbl[i];
      apply(v);
      #1;
      model_eval();
      chk($sformatf("tbl%0d.rf_we", i), 32'(rf_we), 32'(v.e_we));
      chk($sformatf("tbl%0d.rf_a3", i), 32'(rf_a3), 32'(v.e_a3));
      chk($sformatf("tbl%0d.rf_wd", i), rf_wd, v.e_wd);
      chk($sformatf("tbl%0d.mu_ready", i), 32'(mu_ready), 32'(v.e_ready));
      chk($sformatf("tbl%0d.stall", i), 32'(stall), 32'(v.e_stall));
      chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(v.e_busy));
      @(posedge clk);
      model_update();
      @(negedge clk);
    end

    // Random traffic on a narrow register range so hazards and collisions are frequent.
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(99) < 2);
      wb_we    = ($urandom_range(99) < 35);
      wb_rd    = 5'($urandom_range(7));
      wb_wd    = $urandom;
      mu_valid = ($urandom_range(99) < 50);
      mu_rd    = 5'($urandom_range(7));
      mu_wd    = $urandom;
      id_we    = ($urandom_range(99) < 50);
      id_long  = ($urandom_range(99) < 50);
      id_rd    = 5'($urandom_range(7));
      rs1      = 5'($urandom_range(7));
      rs2      = 5'($urandom_range(7));
      #1;
      model_eval();
      chk("rnd.rf_we", 32'(rf_we), 32'(m_we));
      chk("rnd.rf_a3", 32'(rf_a3), 32'(m_a3));
      chk("rnd.rf_wd", rf_wd, m_wd);
      chk("rnd.mu_ready", 32'(mu_ready), 32'(m_ready));
      chk("rnd.stall", 32'(stall), 32'(m_stall));
      chk("rnd.busy", 32'(busy), 32'(m_busy));
      @(posedge clk);
      model_update();
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
